// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, divider cycle count, FSM states
// and the HI/LO result field layout common to the multiplier and divider.
package alu_pkg;

  localparam int N          = 32;
  localparam int DIV_CYCLES = N + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Concatenated {hi, lo} layout: lo holds the quotient/low product,
  // hi holds the remainder/high product.
  localparam int LO_LSB = 0;
  localparam int HI_LSB = N;
  localparam int HILO_W = 2 * N;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract M from R,
// keep the difference and set the quotient bit when it does not go negative.
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   r_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] m_i,
  output logic [N:0]   r_o,
  output logic [N-1:0] q_o
);

  logic [N:0]   r_sh;
  logic [N-1:0] q_sh;
  logic [N:0]   t;

  assign r_sh = {r_i[N-1:0], q_i[N-1]};
  assign q_sh = {q_i[N-2:0], 1'b0};
  // R < M is invariant, so r_sh < 2M and the true difference fits; its
  // sign shows up in the top bit of the N+1-bit result.
  assign t    = r_sh - {1'b0, m_i};

  always_comb begin
    if (!t[N]) begin
      r_o = t;
      q_o = {q_sh[N-1:1], 1'b1};
    end else begin
      r_o = r_sh;
      q_o = q_sh;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider: magnitude restoring division, one quotient bit
// per cycle, sign fix-up in a final cycle. Quotient in lo, remainder in hi.
module div_unit
  import alu_pkg::*;
#(
  parameter int N = alu_pkg::N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] srcA,
  input  logic [N-1:0] srcB,
  input  logic         divCtrl,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         divZero,
  output logic [1:0]   dbg_state
);

  // Handshake: divCtrl is a single-cycle start sampled on the rising edge;
  // busy stays high until the edge that writes hi/lo, and done is high for
  // exactly the one cycle after that edge. A start while busy restarts.

  localparam int CW = $clog2(N + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     r_q, r_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   m_q, m_d;
  logic [N-1:0]   a_q, a_d;
  logic           sa_q, sa_d, sb_q, sb_d, zero_q, zero_d;
  logic [N-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [N:0]     r_step;
  logic [N-1:0]   q_step;

  div_step #(.N(N)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .m_i (m_q),
    .r_o (r_step),
    .q_o (q_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    m_d     = m_q;
    a_d     = a_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    case (state_q)
      RUN: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (zero_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = (sa_q ^ sb_q) ? -q_q : q_q;
          hi_d = sa_q ? -r_q[N-1:0] : r_q[N-1:0];
        end
        dz_d    = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: ;
    endcase

    // A start is honoured in every state; in FIX the result above still lands.
    if (divCtrl) begin
      sa_d    = srcA[N-1];
      sb_d    = srcB[N-1];
      a_d     = srcA;
      q_d     = srcA[N-1] ? -srcA : srcA;
      m_d     = srcB[N-1] ? -srcB : srcB;
      r_d     = '0;
      zero_d  = (srcB == '0);
      cnt_d   = CW'(N);
      busy_d  = 1'b1;
      state_d = RUN;
      if (state_q != FIX) dz_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      a_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      m_q     <= m_d;
      a_q     <= a_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign divZero   = dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random bench for div_unit: results come from a signed
// arithmetic reference model and are matched through an expected queue.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] srcA, srcB;
  logic        divCtrl;
  logic [31:0] hi, lo;
  logic        busy, done, divZero;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  // {divZero, hi, lo}
  logic [64:0] exp_q[$];

  div_unit #(.N(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .srcA      (srcA),
    .srcB      (srcB),
    .divCtrl   (divCtrl),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .divZero   (divZero),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, qv, rv;
    logic [63:0] qb, rb;
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qv = sa / sb;
    rv = sa % sb;
    qb = qv;
    rb = rv;
    return {1'b0, rb[31:0], qb[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one-cycle start pulse; returns at the falling edge after E0
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    srcA    = a;
    srcB    = b;
    divCtrl = 1'b1;
    exp_q.delete();
    exp_q.push_back(model(a, b));
    @(negedge clk);
    divCtrl = 1'b0;
  endtask

  task automatic await_done(input string tag);
    logic [31:0] hi0, lo0;
    logic [64:0] e;
    int k;
    bit seen;
    hi0  = hi;
    lo0  = lo;
    k    = 0;
    seen = 0;
    chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) seen = 1;
      else if (k == 16) begin
        chk({tag, "_hi_held"}, hi, hi0);
        chk({tag, "_lo_held"}, lo, lo0);
      end
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_latency"}, k, 32'd33);
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_lo"}, lo, e[31:0]);
      chk({tag, "_hi"}, hi, e[63:32]);
      chk({tag, "_divzero"}, {31'd0, divZero}, {31'd0, e[64]});
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, hi_prev, lo_prev;
    bit stray;

    reset   = 1'b0;
    divCtrl = 1'b0;
    srcA    = '0;
    srcB    = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_flags", {29'd0, busy, done, divZero}, 32'd0);
    reset = 1'b1;

    issue(32'd100, 32'd7);               await_done("p100_7");
    chk("p100_7_lo_const", lo, 32'd14);
    chk("p100_7_hi_const", hi, 32'd2);
    issue(-32'sd100, 32'd7);             await_done("m100_7");
    chk("m100_7_lo_const", lo, 32'hFFFF_FFF2);
    chk("m100_7_hi_const", hi, 32'hFFFF_FFFE);
    issue(32'd100, -32'sd7);             await_done("p100_m7");
    chk("p100_m7_lo_const", lo, 32'hFFFF_FFF2);
    chk("p100_m7_hi_const", hi, 32'd2);

    issue(32'd7, 32'd0);                 await_done("div0");
    chk("div0_lo_const", lo, 32'hFFFF_FFFF);
    chk("div0_hi_const", hi, 32'd7);
    chk("div0_flag_held", {31'd0, divZero}, 32'd1);
    issue(32'd21, 32'd4);
    chk("div0_cleared", {31'd0, divZero}, 32'd0);
    await_done("after_div0");

    issue(32'h8000_0000, 32'hFFFF_FFFF); await_done("ovf");
    chk("ovf_lo_const", lo, 32'h8000_0000);
    chk("ovf_hi_const", hi, 32'd0);
    issue(32'h8000_0000, 32'd1);         await_done("min_1");
    chk("min_1_lo_const", lo, 32'h8000_0000);

    // abort and restart mid-run
    hi_prev = hi;
    lo_prev = lo;
    stray   = 0;
    issue(32'd1000, 32'd3);
    repeat (9) begin
      @(negedge clk);
      if (done === 1'b1) stray = 1;
    end
    chk("restart_no_early_done", {31'd0, stray}, 32'd0);
    chk("restart_hi_prev", hi, hi_prev);
    chk("restart_lo_prev", lo, lo_prev);
    issue(32'd9, 32'd2);                 await_done("restart");
    chk("restart_lo_const", lo, 32'd4);
    chk("restart_hi_const", hi, 32'd1);

    // asynchronous reset mid-operation
    issue(32'd50, 32'd5);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_flags", {29'd0, busy, done, divZero}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) stray = 1;
    end
    chk("arst_no_done", {31'd0, stray}, 32'd0);
    issue(32'd50, 32'd5);                await_done("post_rst");
    chk("post_rst_lo_const", lo, 32'd10);
    chk("post_rst_hi_const", hi, 32'd0);

    // random operands, mixing wide, small and zero divisors
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 20);
        2:       b = -$urandom_range(1, 20);
        default: b = ($urandom_range(0, 1) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      issue(a, b);
      await_done("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
